uart_command_receiver: RTL and testbench



---
 rtl/iagc_uart_pkg.sv | 15 +
 rtl/uart_command_receiver_rx.sv | 79 +++++++
 rtl/uart_command_receiver.sv | 115 +++++++++++
 tb/tb_uart_command_receiver.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/iagc_uart_pkg.sv
// iagc_uart_pkg: shared constants, command codes and FSM state types for the UART command receiver
package iagc_uart_pkg;
  localparam logic [7:0] FRAME_HEADER      = 8'hA5;
  localparam logic [7:0] CMD_SET_REFERENCE = 8'h01;
  localparam logic [7:0] CMD_SET_GAIN      = 8'h02;
  localparam logic [7:0] CMD_SET_CONTROL   = 8'h03;
  localparam logic [15:0] GAIN_RESET       = 16'h0100;
  localparam logic [1:0]  CONTROL_RESET    = 2'b10;
  typedef enum logic [2:0] {P_HDR, P_CMD, P_DHI, P_DLO, P_CHK} parser_state_e;
  // RX_BREAK holds off after a framing error until the line returns high
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_e;
  function automatic logic cmd_known(input logic [7:0] c);
    return c == CMD_SET_REFERENCE || c == CMD_SET_GAIN || c == CMD_SET_CONTROL;
  endfunction
endpackage

// File: rtl/uart_command_receiver_rx.sv
// uart_rx: 8N1 byte receiver with input synchronizer, mid-bit sampling and framing-error detection
module uart_rx
  import iagc_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10869,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 byte_ready_o,
  output logic                 framing_error_o
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int IW = $clog2(DATA_BITS);
  logic [1:0]           sync_q;
  logic                 rx;
  rx_state_e            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 half_done, bit_done;
  assign rx        = sync_q[1];
  assign half_done = cnt_q == CW'(CLKS_PER_BIT / 2 - 1);
  assign bit_done  = cnt_q == CW'(CLKS_PER_BIT - 1);
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q  <= 2'b11;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      sync_q  <= {sync_q[0], rx_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (!rx) state_d = RX_START;
      end
      RX_START: if (half_done) begin
        cnt_d   = '0;
        idx_d   = '0;
        state_d = rx ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (bit_done) begin
        cnt_d   = '0;
        shift_d = {rx, shift_q[DATA_BITS-1:1]};
        idx_d   = idx_q + 1'b1;
        if (idx_q == IW'(DATA_BITS - 1)) state_d = RX_STOP;
      end
      RX_STOP: if (bit_done) begin
        cnt_d   = '0;
        state_d = rx ? RX_IDLE : RX_BREAK;
      end
      RX_BREAK: begin
        cnt_d = '0;
        if (rx) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end
  always_comb begin
    data_o          = shift_q;
    byte_ready_o    = state_q == RX_STOP && bit_done && rx;
    framing_error_o = state_q == RX_STOP && bit_done && !rx;
  end
endmodule

// File: rtl/uart_command_receiver.sv
// uart_command_receiver: parses 5-byte UART command frames into IAGC configuration registers
module uart_command_receiver
  import iagc_uart_pkg::*;
#(
  parameter int UART_CLK_FREQ       = 100_000_000,
  parameter int UART_BAUDRATE       = 9_200,
  parameter int UART_DATA_SIZE      = 8,
  parameter int AMPLITUDE_DATA_SIZE = 16,
  parameter int TIMEOUT_BITS        = 20,
  parameter logic [AMPLITUDE_DATA_SIZE-1:0] DEFAULT_REFERENCE = 16'h1000
) (
  input  logic                           i_clock,
  input  logic                           i_reset,
  input  logic                           i_rxBit,
  output logic [AMPLITUDE_DATA_SIZE-1:0] o_referenceAmplitude,
  output logic [AMPLITUDE_DATA_SIZE-1:0] o_gainOverride,
  output logic [1:0]                     o_control,
  output logic                           o_cmdValid,
  output logic                           o_frameError,
  output logic [7:0]                     o_errorCount
);
  localparam int CLKS_PER_BIT = UART_CLK_FREQ / UART_BAUDRATE;
  localparam int TO_CYCLES    = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW           = $clog2(TO_CYCLES + 1);
  localparam int AW           = AMPLITUDE_DATA_SIZE;
  logic [UART_DATA_SIZE-1:0] rx_data;
  logic                      byte_ready, framing_error;
  parser_state_e             state_q, state_d;
  logic [UART_DATA_SIZE-1:0] cmd_q, cmd_d, dhi_q, dhi_d, dlo_q, dlo_d;
  logic [TW-1:0]             tmo_q, tmo_d;
  logic [AW-1:0]             ref_q, ref_d, gain_q, gain_d;
  logic [1:0]                ctrl_q, ctrl_d;
  logic [7:0]                ecnt_q, ecnt_d;
  logic                      valid_q, ferr_q;
  logic                      timeout, frame_abort, frame_done, apply, err;
  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT), .DATA_BITS(UART_DATA_SIZE)) u_rx (
    .clk_i           (i_clock),
    .rst_i           (i_reset),
    .rx_i            (i_rxBit),
    .data_o          (rx_data),
    .byte_ready_o    (byte_ready),
    .framing_error_o (framing_error)
  );
  // byteReady wins over a coincident timeout expiry
  assign timeout     = state_q != P_HDR && !byte_ready && tmo_q == TW'(TO_CYCLES - 1);
  assign frame_abort = timeout || (framing_error && state_q != P_HDR);
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= P_HDR;
      cmd_q   <= '0;
      dhi_q   <= '0;
      dlo_q   <= '0;
      tmo_q   <= '0;
      ref_q   <= DEFAULT_REFERENCE;
      gain_q  <= AW'(GAIN_RESET);
      ctrl_q  <= CONTROL_RESET;
      ecnt_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      dhi_q   <= dhi_d;
      dlo_q   <= dlo_d;
      tmo_q   <= tmo_d;
      ref_q   <= ref_d;
      gain_q  <= gain_d;
      ctrl_q  <= ctrl_d;
      ecnt_q  <= ecnt_d;
      valid_q <= apply;
      ferr_q  <= err;
    end
  end
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    dhi_d   = dhi_q;
    dlo_d   = dlo_q;
    tmo_d   = (byte_ready || frame_abort || state_q == P_HDR) ? '0 : tmo_q + 1'b1;
    if (frame_abort) state_d = P_HDR;
    else if (byte_ready) begin
      case (state_q)
        P_HDR: if (rx_data == FRAME_HEADER) state_d = P_CMD;
        P_CMD: begin
          cmd_d   = rx_data;
          state_d = P_DHI;
        end
        P_DHI: begin
          dhi_d   = rx_data;
          state_d = P_DLO;
        end
        P_DLO: begin
          dlo_d   = rx_data;
          state_d = P_CHK;
        end
        default: state_d = P_HDR;
      endcase
    end
  end
  always_comb begin
    frame_done = byte_ready && state_q == P_CHK;
    apply      = frame_done && rx_data == (cmd_q ^ dhi_q ^ dlo_q) && cmd_known(cmd_q);
    err        = frame_abort || (frame_done && !apply);
    ref_d      = (apply && cmd_q == CMD_SET_REFERENCE) ? AW'({dhi_q, dlo_q}) : ref_q;
    gain_d     = (apply && cmd_q == CMD_SET_GAIN) ? AW'({dhi_q, dlo_q}) : gain_q;
    ctrl_d     = (apply && cmd_q == CMD_SET_CONTROL) ? dlo_q[1:0] : ctrl_q;
    ecnt_d     = (err && ecnt_q != 8'hFF) ? ecnt_q + 1'b1 : ecnt_q;
  end
  assign o_referenceAmplitude = ref_q;
  assign o_gainOverride       = gain_q;
  assign o_control            = ctrl_q;
  assign o_cmdValid           = valid_q;
  assign o_frameError         = ferr_q;
  assign o_errorCount         = ecnt_q;
endmodule

// File: tb/tb_uart_command_receiver.sv
// tb_uart_command_receiver: directed frame-level bench for uart_command_receiver at 3 clocks per bit
module tb_uart_command_receiver;
  import iagc_uart_pkg::*;
  localparam int CPB = 3;
  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic [15:0] ref_amp, gain;
  logic [1:0]  ctrl;
  logic        cmd_valid, frame_error;
  logic [7:0]  ecnt;
  int checks = 0, errors = 0;
  int n_valid = 0, n_ferr = 0, n_bytes = 0;
  int b_valid, b_ferr, b_bytes;
  always #5 clk = ~clk;
  uart_command_receiver #(
    .UART_CLK_FREQ(1_200_000), .UART_BAUDRATE(400_000), .UART_DATA_SIZE(8),
    .AMPLITUDE_DATA_SIZE(16), .TIMEOUT_BITS(20), .DEFAULT_REFERENCE(16'h1000)
  ) dut (
    .i_clock(clk), .i_reset(rst), .i_rxBit(rx),
    .o_referenceAmplitude(ref_amp), .o_gainOverride(gain), .o_control(ctrl),
    .o_cmdValid(cmd_valid), .o_frameError(frame_error), .o_errorCount(ecnt)
  );
  always @(negedge clk) begin
    if (cmd_valid) n_valid++;
    if (frame_error) n_ferr++;
    if (dut.byte_ready) n_bytes++;
  end
  task automatic tx_byte(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
  endtask
  task automatic tx_frame(input logic [7:0] c, input logic [7:0] h, input logic [7:0] l, input logic [7:0] k);
    tx_byte(8'hA5, 1'b1);
    tx_byte(c, 1'b1);
    tx_byte(h, 1'b1);
    tx_byte(l, 1'b1);
    tx_byte(k, 1'b1);
  endtask
  task automatic idle(input int bits);
    rx = 1'b1;
    repeat (bits * CPB) @(posedge clk);
    #1;
  endtask
  task automatic mark;
    b_valid = n_valid;
    b_ferr  = n_ferr;
    b_bytes = n_bytes;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks += 6;
    if (ref_amp !== 16'h1000) begin errors++; $display("FAIL reset_ref got %h want 1000", ref_amp); end
    if (gain !== 16'h0100) begin errors++; $display("FAIL reset_gain got %h want 0100", gain); end
    if (ctrl !== 2'b10) begin errors++; $display("FAIL reset_ctrl got %b want 10", ctrl); end
    if (cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", cmd_valid); end
    if (frame_error !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b want 0", frame_error); end
    if (ecnt !== 8'd0) begin errors++; $display("FAIL reset_ecnt got %0d want 0", ecnt); end
    rst = 1'b0;
    idle(2);
  endtask
  task automatic test_reference;
    mark();
    tx_frame(8'h01, 8'h12, 8'h34, 8'h27);
    idle(2);
    checks += 4;
    if (ref_amp !== 16'h1234) begin errors++; $display("FAIL ref_set got %h want 1234", ref_amp); end
    if (n_valid - b_valid != 1) begin errors++; $display("FAIL ref_valid_pulses got %0d want 1", n_valid - b_valid); end
    if (ecnt !== 8'd0) begin errors++; $display("FAIL ref_ecnt got %0d want 0", ecnt); end
    if (gain !== 16'h0100) begin errors++; $display("FAIL ref_gain_untouched got %h want 0100", gain); end
  endtask
  task automatic test_bad_checksum;
    mark();
    tx_frame(8'h02, 8'h02, 8'h00, 8'hFF);
    idle(2);
    checks += 4;
    if (gain !== 16'h0100) begin errors++; $display("FAIL badchk_gain got %h want 0100", gain); end
    if (n_ferr - b_ferr != 1) begin errors++; $display("FAIL badchk_ferr_pulses got %0d want 1", n_ferr - b_ferr); end
    if (n_valid != b_valid) begin errors++; $display("FAIL badchk_valid_pulses got %0d want 0", n_valid - b_valid); end
    if (ecnt !== 8'd1) begin errors++; $display("FAIL badchk_ecnt got %0d want 1", ecnt); end
    mark();
    tx_frame(8'h02, 8'h02, 8'h00, 8'h00);
    idle(2);
    checks += 2;
    if (gain !== 16'h0200) begin errors++; $display("FAIL gain_set got %h want 0200", gain); end
    if (n_valid - b_valid != 1) begin errors++; $display("FAIL gain_valid_pulses got %0d want 1", n_valid - b_valid); end
  endtask
  task automatic test_noise;
    mark();
    tx_byte(8'h00, 1'b1);
    tx_byte(8'hFF, 1'b1);
    tx_byte(8'h5A, 1'b1);
    tx_frame(8'h03, 8'h00, 8'h01, 8'h02);
    idle(2);
    checks += 3;
    if (ctrl !== 2'b01) begin errors++; $display("FAIL noise_ctrl got %b want 01", ctrl); end
    if (n_ferr != b_ferr) begin errors++; $display("FAIL noise_ferr_pulses got %0d want 0", n_ferr - b_ferr); end
    if (ecnt !== 8'd1) begin errors++; $display("FAIL noise_ecnt got %0d want 1", ecnt); end
  endtask
  task automatic test_glitch;
    mark();
    rx = 1'b0;
    @(posedge clk);
    #1;
    idle(12);
    checks += 2;
    if (n_bytes != b_bytes) begin errors++; $display("FAIL glitch_bytes got %0d want 0", n_bytes - b_bytes); end
    if (n_ferr != b_ferr) begin errors++; $display("FAIL glitch_ferr got %0d want 0", n_ferr - b_ferr); end
    tx_frame(8'h03, 8'h00, 8'h02, 8'h01);
    idle(2);
    checks++;
    if (ctrl !== 2'b10) begin errors++; $display("FAIL glitch_after_ctrl got %b want 10", ctrl); end
  endtask
  task automatic test_timeout;
    mark();
    tx_byte(8'hA5, 1'b1);
    tx_byte(8'h01, 1'b1);
    idle(30);
    checks += 3;
    if (n_ferr - b_ferr != 1) begin errors++; $display("FAIL timeout_ferr_pulses got %0d want 1", n_ferr - b_ferr); end
    if (ecnt !== 8'd2) begin errors++; $display("FAIL timeout_ecnt got %0d want 2", ecnt); end
    if (dut.state_q !== P_HDR) begin errors++; $display("FAIL timeout_state got %0d want %0d", dut.state_q, P_HDR); end
    mark();
    tx_frame(8'h01, 8'h00, 8'h10, 8'h11);
    idle(2);
    checks += 2;
    if (ref_amp !== 16'h0010) begin errors++; $display("FAIL timeout_next_ref got %h want 0010", ref_amp); end
    if (n_valid - b_valid != 1) begin errors++; $display("FAIL timeout_next_valid got %0d want 1", n_valid - b_valid); end
  endtask
  task automatic test_framing;
    mark();
    tx_byte(8'hA5, 1'b1);
    tx_byte(8'h01, 1'b0);
    idle(3);
    checks += 3;
    if (n_ferr - b_ferr != 1) begin errors++; $display("FAIL framing_ferr_pulses got %0d want 1", n_ferr - b_ferr); end
    if (ecnt !== 8'd3) begin errors++; $display("FAIL framing_ecnt got %0d want 3", ecnt); end
    if (dut.state_q !== P_HDR) begin errors++; $display("FAIL framing_state got %0d want %0d", dut.state_q, P_HDR); end
  endtask
  task automatic test_saturation;
    mark();
    for (int i = 0; i < 300; i++) tx_frame(8'h02, 8'h02, 8'h00, 8'hFF);
    idle(2);
    checks += 3;
    if (ecnt !== 8'd255) begin errors++; $display("FAIL sat_ecnt got %0d want 255", ecnt); end
    if (n_ferr - b_ferr != 300) begin errors++; $display("FAIL sat_ferr_pulses got %0d want 300", n_ferr - b_ferr); end
    if (gain !== 16'h0200) begin errors++; $display("FAIL sat_gain got %h want 0200", gain); end
  endtask
  task automatic test_reset_midframe;
    tx_byte(8'hA5, 1'b1);
    tx_byte(8'h01, 1'b1);
    rx = 1'b0;
    repeat (CPB) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks += 5;
    if (ref_amp !== 16'h1000) begin errors++; $display("FAIL midrst_ref got %h want 1000", ref_amp); end
    if (gain !== 16'h0100) begin errors++; $display("FAIL midrst_gain got %h want 0100", gain); end
    if (ctrl !== 2'b10) begin errors++; $display("FAIL midrst_ctrl got %b want 10", ctrl); end
    if (ecnt !== 8'd0) begin errors++; $display("FAIL midrst_ecnt got %0d want 0", ecnt); end
    if (dut.state_q !== P_HDR) begin errors++; $display("FAIL midrst_state got %0d want %0d", dut.state_q, P_HDR); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);
    mark();
    tx_frame(8'h01, 8'hAB, 8'hCD, 8'h67);
    idle(2);
    checks += 3;
    if (ref_amp !== 16'hABCD) begin errors++; $display("FAIL midrst_ref_after got %h want abcd", ref_amp); end
    if (n_valid - b_valid != 1) begin errors++; $display("FAIL midrst_valid got %0d want 1", n_valid - b_valid); end
    if (ecnt !== 8'd0) begin errors++; $display("FAIL midrst_ecnt_after got %0d want 0", ecnt); end
  endtask
  initial begin
    test_reset();
    test_reference();
    test_bad_checksum();
    test_noise();
    test_glitch();
    test_timeout();
    test_framing();
    test_saturation();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
